// File: rtl/branch_flush_ctrl.sv
// branch_flush_ctrl: pipeline sequencer for the IF/ID/EX stage registers.
//  - 2-bit saturating branch history table supplies the EX predict-jump bit.
//  - Mispredicts resolved in EX schedule a one-cycle flush/redirect.
//  - Load-use stalls insert a bubble into ID/EX while IF/ID holds.
// Optional feature macro: PERF_CNT_EN (saturating 16-bit branch/mispredict counters).
module branch_flush_ctrl #(
    parameter int unsigned IdxBits = 4,
    parameter int unsigned InitCnt = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               tick_i,
    input  logic               id_is_branch_i,
    input  logic [IdxBits-1:0] id_pc_idx_i,
    input  logic               ex_br_valid_i,
    input  logic [IdxBits-1:0] ex_pc_idx_i,
    input  logic               ex_taken_i,
    input  logic               ex_pred_i,
    input  logic               hz_stall_i,
    output logic               pj_d_o,
    output logic [1:0]         pc_sel_o,
    output logic               if_id_en_o,
    output logic               id_ex_en_o,
    output logic               if_id_flush_o,
    output logic               id_ex_flush_o,
    output logic [15:0]        perf_branches_o,
    output logic [15:0]        perf_mispred_o
);

    localparam int unsigned Entries = 1 << IdxBits;
    localparam logic [1:0]  PcSeqPc  = 2'b00;
    localparam logic [1:0]  PcSelPred = 2'b01;
    localparam logic [1:0]  PcSelEx  = 2'b10;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic       flush_q, flush_d;

    logic [1:0] bht_rd [Entries];
    logic       mispredict;
    logic       in_run;
    logic       bht_upd;

    logic       pj;
    logic [1:0] pc_sel;
    logic       if_en;
    logic       ex_en;
    logic       bubble;

    assign mispredict = ex_br_valid_i & (ex_taken_i != ex_pred_i);
    assign in_run     = (state_q == ST_RUN);
    // Branches resolving while FLUSH or INIT is active are discarded.
    assign bht_upd    = in_run & tick_i & ex_br_valid_i;

    // State and registered flush flag advance only on Tick; reset is immediate.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            flush_q <= 1'b0;
        end else if (tick_i) begin
            state_q <= state_d;
            flush_q <= flush_d;
        end
    end

    // Next-state and output decode; mispredict outranks a pending stall.
    always_comb begin
        state_d = state_q;
        pj      = 1'b0;
        pc_sel  = PcSeqPc;
        if_en   = 1'b0;
        ex_en   = 1'b0;
        bubble  = 1'b0;
        case (state_q)
            ST_INIT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                pj = id_is_branch_i & bht_rd[id_pc_idx_i][1];
                if (mispredict) begin
                    state_d = ST_FLUSH;
                    pc_sel  = pj ? PcSelPred : PcSeqPc;
                    if_en   = 1'b1;
                    ex_en   = 1'b1;
                end else if (hz_stall_i) begin
                    pc_sel  = PcSeqPc;
                    if_en   = 1'b0;
                    ex_en   = 1'b1;
                    bubble  = 1'b1;
                end else begin
                    pc_sel  = pj ? PcSelPred : PcSeqPc;
                    if_en   = 1'b1;
                    ex_en   = 1'b1;
                end
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
                pc_sel  = PcSelEx;
                if_en   = 1'b1;
                ex_en   = 1'b1;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign flush_d       = (state_d == ST_FLUSH);
    assign pj_d_o        = pj;
    assign pc_sel_o      = pc_sel;
    assign if_id_en_o    = if_en & tick_i;
    assign id_ex_en_o    = ex_en & tick_i;
    assign if_id_flush_o = flush_q;
    assign id_ex_flush_o = flush_q | bubble;

    // One saturating 2-bit counter per BHT entry; ID reads the pre-update value.
    for (genvar gi = 0; gi < Entries; gi++) begin : g_bht
        logic [1:0] cnt_q, cnt_d;
        logic       hit;

        assign hit = bht_upd && (ex_pc_idx_i == IdxBits'(gi));

        // Saturating increment on taken, saturating decrement on not-taken.
        always_comb begin
            cnt_d = cnt_q;
            if (hit) begin
                if (ex_taken_i) begin
                    cnt_d = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;
                end else begin
                    cnt_d = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
                end
            end
        end

        // Counter register, cleared to the weak initial value on reset.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt_q <= 2'(InitCnt);
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign bht_rd[gi] = cnt_q;
    end

`ifdef PERF_CNT_EN
    logic [15:0] perf_br_q, perf_br_d;
    logic [15:0] perf_mp_q, perf_mp_d;

    // Saturating event counters; only a reset clears them.
    always_comb begin
        perf_br_d = perf_br_q;
        perf_mp_d = perf_mp_q;
        if (bht_upd && (perf_br_q != 16'hFFFF)) begin
            perf_br_d = perf_br_q + 16'd1;
        end
        if (bht_upd && mispredict && (perf_mp_q != 16'hFFFF)) begin
            perf_mp_d = perf_mp_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_br_q <= 16'h0000;
            perf_mp_q <= 16'h0000;
        end else begin
            perf_br_q <= perf_br_d;
            perf_mp_q <= perf_mp_d;
        end
    end

    assign perf_branches_o = perf_br_q;
    assign perf_mispred_o  = perf_mp_q;
`else
    assign perf_branches_o = 16'h0000;
    assign perf_mispred_o  = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_flush_ctrl.sv
// Scoreboard bench for branch_flush_ctrl: each cycle pushes the expected
// outputs when stimulus is driven, then pops and compares once settled.
module tb_branch_flush_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        id_is_branch;
    logic [3:0]  id_pc_idx;
    logic        ex_br_valid;
    logic [3:0]  ex_pc_idx;
    logic        ex_taken;
    logic        ex_pred;
    logic        hz_stall;
    logic        pj_d;
    logic [1:0]  pc_sel;
    logic        if_id_en;
    logic        id_ex_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic [15:0] perf_branches;
    logic [15:0] perf_mispred;

    branch_flush_ctrl #(.IdxBits(4), .InitCnt(1)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .tick_i          (tick),
        .id_is_branch_i  (id_is_branch),
        .id_pc_idx_i     (id_pc_idx),
        .ex_br_valid_i   (ex_br_valid),
        .ex_pc_idx_i     (ex_pc_idx),
        .ex_taken_i      (ex_taken),
        .ex_pred_i       (ex_pred),
        .hz_stall_i      (hz_stall),
        .pj_d_o          (pj_d),
        .pc_sel_o        (pc_sel),
        .if_id_en_o      (if_id_en),
        .id_ex_en_o      (id_ex_en),
        .if_id_flush_o   (if_id_flush),
        .id_ex_flush_o   (id_ex_flush),
        .perf_branches_o (perf_branches),
        .perf_mispred_o  (perf_mispred)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        pj;
        logic [1:0]  pc;
        logic        ife;
        logic        exe;
        logic        ifl;
        logic        exl;
        logic [15:0] pb;
        logic [15:0] pm;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] br_m = 16'h0000;
    logic [15:0] mp_m = 16'h0000;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        if (obs !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, req);
        end
    endtask

    function automatic exp_t mk(input int pj, input int pc, input int ife,
                                input int exe, input int ifl, input int exl);
        exp_t e;
        e.pj  = 1'(pj);
        e.pc  = 2'(pc);
        e.ife = 1'(ife);
        e.exe = 1'(exe);
        e.ifl = 1'(ifl);
        e.exl = 1'(exl);
`ifdef PERF_CNT_EN
        e.pb  = br_m;
        e.pm  = mp_m;
`else
        e.pb  = 16'h0000;
        e.pm  = 16'h0000;
`endif
        return e;
    endfunction

    task automatic compare_head(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_val({tag, ".queue_empty"}, 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check_val({tag, ".pj_d"},          {31'd0, pj_d},          {31'd0, e.pj});
        check_val({tag, ".pc_sel"},        {30'd0, pc_sel},        {30'd0, e.pc});
        check_val({tag, ".if_id_en"},      {31'd0, if_id_en},      {31'd0, e.ife});
        check_val({tag, ".id_ex_en"},      {31'd0, id_ex_en},      {31'd0, e.exe});
        check_val({tag, ".if_id_flush"},   {31'd0, if_id_flush},   {31'd0, e.ifl});
        check_val({tag, ".id_ex_flush"},   {31'd0, id_ex_flush},   {31'd0, e.exl});
        check_val({tag, ".perf_branches"}, {16'd0, perf_branches}, {16'd0, e.pb});
        check_val({tag, ".perf_mispred"},  {16'd0, perf_mispred},  {16'd0, e.pm});
    endtask

    task automatic drive(input int br, input int ii, input int v, input int xi,
                         input int tk, input int pr, input int st, input int tck);
        id_is_branch = 1'(br);
        id_pc_idx    = 4'(ii);
        ex_br_valid  = 1'(v);
        ex_pc_idx    = 4'(xi);
        ex_taken     = 1'(tk);
        ex_pred      = 1'(pr);
        hz_stall     = 1'(st);
        tick         = 1'(tck);
    endtask

    // One clock cycle: drive, push expectation, compare after settling, clock.
    // 'run' marks cycles the bench expects the controller to be in RUN, which
    // decides whether the resolved branch is counted by the perf model.
    task automatic cyc(input string tag, input int br, input int ii, input int v, input int xi,
                       input int tk, input int pr, input int st, input int tck,
                       input int run, input exp_t e);
        drive(br, ii, v, xi, tk, pr, st, tck);
        exp_q.push_back(e);
        #2;
        compare_head(tag);
        if (run != 0 && tck != 0 && v != 0) begin
            if (br_m != 16'hFFFF) br_m = br_m + 16'd1;
            if (tk != pr && mp_m != 16'hFFFF) mp_m = mp_m + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        cyc("reset", 0, 0, 0, 0, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 0, 0));
        rst = 1'b0;

        // INIT lasts one Tick cycle, then RUN with both enables up.
        cyc("init",  1, 3, 0, 0, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 0, 0));
        cyc("run0",  0, 0, 0, 0, 0, 0, 0, 1, 1, mk(0, 0, 1, 1, 0, 0));

        // Tick low: enables forced off, a mispredict is not acted upon.
        cyc("tick0",       0, 0, 1, 7, 1, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0));
        cyc("tick0_after", 0, 0, 0, 0, 0, 0, 0, 1, 1, mk(0, 0, 1, 1, 0, 0));

        // Idx 3 trained taken twice; second update is read pre-update (cnt 2).
        cyc("bht3_t1", 0, 0, 1, 3, 1, 1, 0, 1, 1, mk(0, 0, 1, 1, 0, 0));
        cyc("bht3_t2", 1, 3, 1, 3, 1, 1, 0, 1, 1, mk(1, 1, 1, 1, 0, 0));
        cyc("pred3",   1, 3, 0, 0, 0, 0, 0, 1, 1, mk(1, 1, 1, 1, 0, 0));
        // Upper saturation: 3 stays 3, one not-taken leaves it at 2.
        cyc("bht3_t3", 0, 0, 1, 3, 1, 1, 0, 1, 1, mk(0, 0, 1, 1, 0, 0));
        cyc("bht3_n1", 0, 0, 1, 3, 0, 0, 0, 1, 1, mk(0, 0, 1, 1, 0, 0));
        cyc("pred3_b", 1, 3, 0, 0, 0, 0, 0, 1, 1, mk(1, 1, 1, 1, 0, 0));

        // Mispredict -> one FLUSH cycle; branch seen during FLUSH is ignored.
        cyc("mp_ex",   0, 0, 1, 7, 1, 0, 0, 1, 1, mk(0, 0, 1, 1, 0, 0));
        cyc("flush",   0, 0, 1, 7, 0, 1, 0, 1, 0, mk(0, 2, 1, 1, 1, 1));
        cyc("post_fl", 1, 7, 0, 0, 0, 0, 0, 1, 1, mk(1, 1, 1, 1, 0, 0));

        // Stall for three cycles with a mispredict in the second.
        cyc("st1",     1, 3, 0, 0, 0, 0, 1, 1, 1, mk(1, 0, 0, 1, 0, 1));
        cyc("st2_mp",  0, 0, 1, 9, 0, 1, 1, 1, 1, mk(0, 0, 1, 1, 0, 0));
        cyc("st3_fl",  0, 0, 0, 0, 0, 0, 1, 1, 0, mk(0, 2, 1, 1, 1, 1));
        cyc("st_done", 0, 0, 0, 0, 0, 0, 0, 1, 1, mk(0, 0, 1, 1, 0, 0));

        // Idx 5 driven not-taken four times saturates at 0.
        for (int i = 0; i < 4; i++) begin
            cyc("bht5_n", 0, 0, 1, 5, 0, 0, 0, 1, 1, mk(0, 0, 1, 1, 0, 0));
        end
        cyc("pred5_a",      1, 5, 0, 0, 0, 0, 0, 1, 1, mk(0, 0, 1, 1, 0, 0));
        cyc("bht5_t_same",  1, 5, 1, 5, 1, 1, 0, 1, 1, mk(0, 0, 1, 1, 0, 0));
        cyc("pred5_b",      1, 5, 0, 0, 0, 0, 0, 1, 1, mk(0, 0, 1, 1, 0, 0));
        cyc("bht5_t2_same", 1, 5, 1, 5, 1, 1, 0, 1, 1, mk(0, 0, 1, 1, 0, 0));
        cyc("pred5_c",      1, 5, 0, 0, 0, 0, 0, 1, 1, mk(1, 1, 1, 1, 0, 0));

`ifdef PERF_CNT_EN
        // Counter saturation: 65537 resolved branches leave perf_branches at FFFF.
        drive(0, 0, 1, 0, 1, 1, 0, 1);
        for (int i = 0; i < 65537; i++) begin
            @(posedge clk);
            #1;
            if (br_m != 16'hFFFF) br_m = br_m + 16'd1;
        end
        cyc("perf_sat", 0, 0, 0, 0, 0, 0, 0, 1, 1, mk(0, 0, 1, 1, 0, 0));
        check_val("perf_sat_value", {16'd0, perf_branches}, 32'h0000FFFF);
`endif

        // Reset asserted mid-FLUSH returns outputs to reset values immediately.
        cyc("mp2", 0, 0, 1, 2, 0, 1, 0, 1, 1, mk(0, 0, 1, 1, 0, 0));
        drive(1, 3, 0, 0, 0, 0, 0, 1);
        exp_q.push_back(mk(0, 2, 1, 1, 1, 1));
        #2;
        compare_head("rf_pre");
        rst  = 1'b1;
        br_m = 16'h0000;
        mp_m = 16'h0000;
        #1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        compare_head("rf_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("rf_init", 1, 3, 0, 0, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 0, 0));
        // BHT back at InitCnt: idx 3 predicts not-taken again.
        cyc("rf_run",  1, 3, 0, 0, 0, 0, 0, 1, 1, mk(0, 0, 1, 1, 0, 0));

        check_val("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
